receive: RTL and testbench
==========================

# receive

PCS receive state machine for the 1000BASE-X physical coding sublayer. It sits between the synchronization block and the GMII receive side. It consumes one 10-bit code-group per clock on `SUDI` and detects idle, start-of-packet, data, and end-of-packet sequences. It drives `RXD`, `RX_DV`, `RX_ER` and `receiving`.

## Interface
Parameters: none.
- `clk`  in  1  receive clock; all state updates on rising edge
- `mr_main_reset`  in  1  asynchronous, active-low reset
- `rx_even`  in  1  even/odd code-group alignment flag from synchronization
- `SUDI`  in  10  current code-group
- `xmit`  in  3  transmit mode; `3'b010` = DATA, any other value = not DATA
- `RX_CLK`  in  1  reserved; no effect on behaviour
- `RXD`  out  8  received octet
- `RX_DV`  out  1  receive data valid
- `RX_ER`  out  1  receive error
- `receiving`  out  1  carrier/packet in progress

## Operation
Code-group classification (combinational). Each special group matches either running-disparity form:
- K28.5 (comma): `1100000101` or `0011111010`
- /S/: `0010010111` or `1101101000`
- /T/: `0100010111` or `1011101000`
- /R/: `0001010111` or `1110101000`
- Any other value is a data group. Its octet is `SUDI[7:0]`.

All outputs are registered and loaded with the values of the state being entered. States and per-state outputs (`receiving` / `RX_DV` / `RX_ER` / `RXD`), with transitions:
- **WAIT_FOR_K** (0/0/0/00)
  - K28.5 and `rx_even`=1 → RX_K.
  - Otherwise stay.
- **RX_K** (0/0/0/00)
  - Data and `xmit`=DATA → IDLE_D.
  - Anything else → WAIT_FOR_K.
- **IDLE_D** (0/0/0/00)
  - K28.5 → RX_K.
  - /S/ → START_OF_PACKET.
  - /T/ or /R/ → FALSE_CARRIER.
  - Data → stay.
- **FALSE_CARRIER** (1/0/1/0x0E)
  - K28.5 → RX_K.
  - Otherwise stay.
- **START_OF_PACKET** (1/1/0/0x55)
  - → RECEIVE unconditionally.
- **RECEIVE** (1/1/0/`SUDI[7:0]`)
  - Data → stay, loading the new octet each cycle.
  - /T/ → EPD_T.
  - K28.5 → EARLY_END.
  - /S/ or /R/ → RX_DATA_ERROR.
- **RX_DATA_ERROR** (1/1/1/00)
  - /T/ → EPD_T.
  - K28.5 → EARLY_END.
  - Otherwise stay.
- **EPD_T** (1/0/0/00)
  - /R/ → TRI_RRI.
  - Anything else → EARLY_END.
- **TRI_RRI** (0/0/0/00)
  - K28.5 → RX_K.
  - /R/ → stay.
  - Otherwise → WAIT_FOR_K.
- **EARLY_END** (0/0/1/00)
  - → IDLE_D unconditionally.

Other rules:
- `rx_even` is only checked in WAIT_FOR_K.
- `xmit` is only checked in RX_K. A change of `xmit` mid-packet has no effect.
- Unused state encodings → WAIT_FOR_K with all outputs 0.

## Timing
- Reset: `mr_main_reset`=0 forces state WAIT_FOR_K and `RXD`=0x00, `RX_DV`=0, `RX_ER`=0, `receiving`=0.
  - The reset is asynchronous and takes effect immediately, including mid-packet.
  - Release is sampled on the next rising edge.
- Latency: a code-group sampled at edge n drives the outputs after edge n; one clock.
- Packet framing: /S/ at edge n gives 0x55 with `RX_DV`=1 from edge n. The first data octet appears after edge n+1.
- End of packet: /T/ drops `RX_DV` one cycle after the last data octet. `receiving` falls on /R/ (TRI_RRI).
- There is no handshake; one code-group is processed per clock, with no stall.

## Test plan
- **Reset.** Hold `mr_main_reset`=0 with any `SUDI` → all outputs 0, state WAIT_FOR_K. Assert reset mid-packet → outputs clear asynchronously, before the next edge.
- **Link acquisition.**
  - `rx_even`=1, `SUDI`=`1100000101` → RX_K.
  - Then `xmit`=`010`, `SUDI`=`0100101011` → IDLE_D; all outputs stay 0.
  - K28.5 again → RX_K.
  - Data with `xmit`=`001` → WAIT_FOR_K.
- **Full packet.** From IDLE_D, send /S/, then data 0x01, 0x02, 0x03, 0x04, 0x42, 0x50, 0x9A, 0xA6, then /T/, /R/, K28.5:
  - `RXD` = 0x55, then 01…A6 with `RX_DV`=1, `receiving`=1, `RX_ER`=0.
  - Then `RX_DV`=0; `receiving`=0 on /R/; RX_K on K28.5.
- **Early end.** /S/, 0x11, then K28.5 → `RX_ER`=1 for one cycle (EARLY_END), then IDLE_D.
- **Data error.** /S/, 0x22, then /R/ inside the packet → `RX_DV`=1, `RX_ER`=1 until /T/, then /R/ → TRI_RRI.
- **False carrier.** /T/ in IDLE_D → `RX_ER`=1, `RXD`=0x0E, `receiving`=1 until K28.5 → RX_K.

Source files
------------

// File: rtl/receive.sv
// 1000BASE-X PCS receive state machine.
// Classifies each incoming 10-bit code-group, tracks idle/packet framing and
// drives the GMII receive outputs one clock after the group is sampled.
module receive (
  input  logic       clk,
  input  logic       mr_main_reset,
  input  logic       rx_even,
  input  logic [9:0] SUDI,
  input  logic [2:0] xmit,
  input  logic       RX_CLK,
  output logic [7:0] RXD,
  output logic       RX_DV,
  output logic       RX_ER,
  output logic       receiving
);

  localparam logic [2:0] XMIT_DATA = 3'b010;

  typedef enum logic [3:0] {
    WAIT_FOR_K      = 4'd0,
    RX_K            = 4'd1,
    IDLE_D          = 4'd2,
    FALSE_CARRIER   = 4'd3,
    START_OF_PACKET = 4'd4,
    RECEIVE         = 4'd5,
    RX_DATA_ERROR   = 4'd6,
    EPD_T           = 4'd7,
    TRI_RRI         = 4'd8,
    EARLY_END       = 4'd9
  } state_t;

  state_t     state, nxt;
  logic       is_k, is_s, is_t, is_r, is_d;
  logic [7:0] rxd_n;
  logic       dv_n, er_n, rcv_n;

  // RX_CLK carries no behaviour; tie it off explicitly.
  logic unused_rx_clk;
  assign unused_rx_clk = RX_CLK;

  // Special code-group decode, both running-disparity forms.
  always_comb begin
    is_k = (SUDI == 10'b1100000101) || (SUDI == 10'b0011111010);
    is_s = (SUDI == 10'b0010010111) || (SUDI == 10'b1101101000);
    is_t = (SUDI == 10'b0100010111) || (SUDI == 10'b1011101000);
    is_r = (SUDI == 10'b0001010111) || (SUDI == 10'b1110101000);
    is_d = !(is_k || is_s || is_t || is_r);
  end

  // Next state, then the outputs belonging to the state being entered.
  always_comb begin
    nxt = state;
    case (state)
      WAIT_FOR_K:      if (is_k && rx_even) nxt = RX_K;
      RX_K:            nxt = (is_d && xmit == XMIT_DATA) ? IDLE_D : WAIT_FOR_K;
      IDLE_D: begin
        if (is_k)              nxt = RX_K;
        else if (is_s)         nxt = START_OF_PACKET;
        else if (is_t || is_r) nxt = FALSE_CARRIER;
      end
      FALSE_CARRIER:   if (is_k) nxt = RX_K;
      START_OF_PACKET: nxt = RECEIVE;
      RECEIVE: begin
        if (is_t)              nxt = EPD_T;
        else if (is_k)         nxt = EARLY_END;
        else if (is_s || is_r) nxt = RX_DATA_ERROR;
      end
      RX_DATA_ERROR: begin
        if (is_t)      nxt = EPD_T;
        else if (is_k) nxt = EARLY_END;
      end
      EPD_T:           nxt = is_r ? TRI_RRI : EARLY_END;
      TRI_RRI: begin
        if (is_k)       nxt = RX_K;
        else if (!is_r) nxt = WAIT_FOR_K;
      end
      EARLY_END:       nxt = IDLE_D;
      default:         nxt = WAIT_FOR_K;
    endcase

    rxd_n = 8'h00;
    dv_n  = 1'b0;
    er_n  = 1'b0;
    rcv_n = 1'b0;
    case (nxt)
      FALSE_CARRIER:   begin rcv_n = 1'b1; er_n = 1'b1; rxd_n = 8'h0E; end
      START_OF_PACKET: begin rcv_n = 1'b1; dv_n = 1'b1; rxd_n = 8'h55; end
      RECEIVE:         begin rcv_n = 1'b1; dv_n = 1'b1; rxd_n = SUDI[7:0]; end
      RX_DATA_ERROR:   begin rcv_n = 1'b1; dv_n = 1'b1; er_n = 1'b1; end
      EPD_T:           rcv_n = 1'b1;
      EARLY_END:       er_n = 1'b1;
      default:         ;
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state     <= WAIT_FOR_K;
      RXD       <= 8'h00;
      RX_DV     <= 1'b0;
      RX_ER     <= 1'b0;
      receiving <= 1'b0;
    end else begin
      state     <= nxt;
      RXD       <= rxd_n;
      RX_DV     <= dv_n;
      RX_ER     <= er_n;
      receiving <= rcv_n;
    end
  end

endmodule

// File: tb/tb_receive.sv
// Bench for the PCS receive state machine: directed framing scenarios with
// hard-coded expectations plus a randomized run against a table-driven model.
module tb_receive;
  logic       clk = 1'b0, RX_CLK = 1'b0;
  logic       mr_main_reset = 1'b0, rx_even = 1'b0;
  logic [9:0] SUDI = 10'd0;
  logic [2:0] xmit = 3'd0;
  logic [7:0] RXD;
  logic       RX_DV, RX_ER, receiving;
  logic [10:0] obs;

  always #5 clk = ~clk;
  always #7 RX_CLK = ~RX_CLK;

  receive dut (
    .clk(clk), .mr_main_reset(mr_main_reset), .rx_even(rx_even), .SUDI(SUDI),
    .xmit(xmit), .RX_CLK(RX_CLK), .RXD(RXD), .RX_DV(RX_DV), .RX_ER(RX_ER),
    .receiving(receiving)
  );

  // observed = {RXD, RX_DV, RX_ER, receiving}
  assign obs = {RXD, RX_DV, RX_ER, receiving};

  int n_cmp = 0, n_bad = 0;

  localparam logic [9:0] GK = 10'b1100000101, GKN = 10'b0011111010;
  localparam logic [9:0] GS = 10'b0010010111, GSN = 10'b1101101000;
  localparam logic [9:0] GT = 10'b0100010111, GTN = 10'b1011101000;
  localparam logic [9:0] GR = 10'b0001010111, GRN = 10'b1110101000;
  localparam logic [2:0] XD = 3'b010;

  // Model: states and symbols as plain integers, transitions as a table.
  localparam int WK = 0, RK = 1, ID = 2, FC = 3, SP = 4, RC = 5, DE = 6, ET = 7, TR = 8, EE = 9;
  localparam int SK = 0, SS = 1, ST = 2, SR = 3, SD = 4;
  int tbl [0:9][0:4] = '{
    '{RK, WK, WK, WK, WK},   // WK (K only with rx_even)
    '{WK, WK, WK, WK, ID},   // RK (data only with xmit=DATA)
    '{RK, SP, FC, FC, ID},   // ID
    '{RK, FC, FC, FC, FC},   // FC
    '{RC, RC, RC, RC, RC},   // SP
    '{EE, DE, ET, DE, RC},   // RC
    '{EE, DE, ET, DE, DE},   // DE
    '{EE, EE, EE, TR, EE},   // ET
    '{RK, WK, WK, TR, WK},   // TR
    '{ID, ID, ID, ID, ID}    // EE
  };
  int          m_st = WK;
  logic [10:0] m_exp = 11'd0;

  function automatic int sym_of(input logic [9:0] g);
    if (g == GK || g == GKN) return SK;
    if (g == GS || g == GSN) return SS;
    if (g == GT || g == GTN) return ST;
    if (g == GR || g == GRN) return SR;
    return SD;
  endfunction

  function automatic logic [10:0] out_of(input int st, input logic [9:0] g);
    case (st)
      FC:      return {8'h0E, 3'b011};
      SP:      return {8'h55, 3'b101};
      RC:      return {g[7:0], 3'b101};
      DE:      return {8'h00, 3'b111};
      ET:      return {8'h00, 3'b001};
      EE:      return {8'h00, 3'b010};
      default: return 11'd0;
    endcase
  endfunction

  task automatic model_step(input logic [9:0] g, input logic ev, input logic [2:0] xm);
    int n;
    if (!mr_main_reset) begin m_st = WK; m_exp = 11'd0; return; end
    n = tbl[m_st][sym_of(g)];
    if (m_st == WK && !ev) n = WK;
    if (m_st == RK && xm != XD) n = WK;
    m_st  = n;
    m_exp = out_of(n, g);
  endtask

  // Present one code-group for one edge; returns #1 after that edge.
  task automatic drive(input logic [9:0] g, input logic ev, input logic [2:0] xm);
    @(negedge clk);
    SUDI = g; rx_even = ev; xmit = xm;
    @(posedge clk);
    model_step(g, ev, xm);
    #1;
  endtask

  task automatic go_idle();
    @(negedge clk); mr_main_reset = 1'b0; m_st = WK; m_exp = 11'd0;
    @(negedge clk); mr_main_reset = 1'b1;
    drive(GK, 1'b1, XD);
    drive(10'b0100101011, 1'b1, XD);
  endtask

  task automatic test_reset();
    mr_main_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(10'($urandom), 1'($urandom), 3'($urandom));
      n_cmp++;
      if (obs !== 11'd0) begin
        n_bad++; $display("FAIL reset_hold cyc=%0d got=%h exp=000", i, obs);
      end
    end
    @(negedge clk); mr_main_reset = 1'b1;
  endtask

  task automatic test_link_acq();
    logic [9:0]  g [9] = '{GK, 10'b0100101011, GKN, 10'h011, GT, GK, GT, GK, 10'h033};
    logic        v [9] = '{1, 1, 1, 1, 1, 0, 1, 1, 1};
    logic [2:0]  x [9] = '{XD, XD, XD, 3'b001, XD, XD, XD, XD, XD};
    go_idle();
    @(negedge clk); mr_main_reset = 1'b0; m_st = WK; m_exp = 11'd0;
    @(negedge clk); mr_main_reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(g[i], v[i], x[i]);
      n_cmp++;
      if (obs !== 11'd0) begin
        n_bad++; $display("FAIL link_acq step=%0d got=%h exp=000", i, obs);
      end
    end
    // K with rx_even, data with DATA -> IDLE_D; /T/ then shows a false carrier.
    drive(GT, 1'b1, XD);
    n_cmp++;
    if (obs !== {8'h0E, 3'b011}) begin
      n_bad++; $display("FAIL link_acq_idle got=%h exp=%h", obs, {8'h0E, 3'b011});
    end
  endtask

  task automatic test_full_packet();
    logic [9:0]  g [14] = '{GS, 10'h001, 10'h002, 10'h003, 10'h004, 10'h042, 10'h050,
                            10'h09A, 10'h0A6, GT, GR, GK, 10'h0C3, GSN};
    logic [10:0] e [14] = '{{8'h55,3'b101}, {8'h01,3'b101}, {8'h02,3'b101}, {8'h03,3'b101},
                            {8'h04,3'b101}, {8'h42,3'b101}, {8'h50,3'b101}, {8'h9A,3'b101},
                            {8'hA6,3'b101}, {8'h00,3'b001}, 11'd0, 11'd0, 11'd0,
                            {8'h55,3'b101}};
    go_idle();
    for (int i = 0; i < 14; i++) begin
      drive(g[i], 1'b0, XD);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL full_packet step=%0d got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_early_end();
    logic [9:0]  g [5] = '{GS, 10'h011, GKN, 10'h044, GS};
    logic [10:0] e [5] = '{{8'h55,3'b101}, {8'h11,3'b101}, {8'h00,3'b010}, 11'd0,
                           {8'h55,3'b101}};
    go_idle();
    for (int i = 0; i < 5; i++) begin
      drive(g[i], 1'b0, 3'b000);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL early_end step=%0d got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_data_error();
    logic [9:0]  g [7] = '{GS, 10'h022, GRN, 10'h0AB, GSN, GT, GR};
    logic [10:0] e [7] = '{{8'h55,3'b101}, {8'h22,3'b101}, {8'h00,3'b111}, {8'h00,3'b111},
                           {8'h00,3'b111}, {8'h00,3'b001}, 11'd0};
    go_idle();
    for (int i = 0; i < 7; i++) begin
      drive(g[i], 1'b1, 3'b100);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL data_error step=%0d got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_false_carrier();
    logic [9:0]  g [6] = '{GTN, 10'h0F0, GS, GR, GK, 10'h012};
    logic [10:0] e [6] = '{{8'h0E,3'b011}, {8'h0E,3'b011}, {8'h0E,3'b011}, {8'h0E,3'b011},
                           11'd0, 11'd0};
    go_idle();
    for (int i = 0; i < 6; i++) begin
      drive(g[i], 1'b1, XD);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL false_carrier step=%0d got=%h exp=%h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    drive(GS, 1'b0, XD);
    drive(10'h05A, 1'b0, XD);
    n_cmp++;
    if (obs !== {8'h5A, 3'b101}) begin
      n_bad++; $display("FAIL async_pre got=%h exp=%h", obs, {8'h5A, 3'b101});
    end
    #2 mr_main_reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 11'd0) begin
      n_bad++; $display("FAIL async_reset got=%h exp=000", obs);
    end
    m_st = WK; m_exp = 11'd0;
    @(negedge clk); mr_main_reset = 1'b1;
    drive(GT, 1'b1, XD);
    n_cmp++;
    if (obs !== 11'd0) begin
      n_bad++; $display("FAIL async_post got=%h exp=000", obs);
    end
  endtask

  task automatic rand_grp(output logic [9:0] g);
    int r = $urandom_range(0, 11);
    logic f = 1'($urandom);
    case (r)
      0, 1:    g = f ? GK : GKN;
      2:       g = f ? GS : GSN;
      3:       g = f ? GT : GTN;
      4:       g = f ? GR : GRN;
      default: begin
        g = 10'($urandom);
        while (sym_of(g) != SD) g = 10'($urandom);
      end
    endcase
  endtask

  task automatic test_random();
    logic [9:0] g;
    logic       ev;
    logic [2:0] xm;
    go_idle();
    for (int i = 0; i < 800; i++) begin
      rand_grp(g);
      ev = ($urandom_range(0, 3) != 0);
      xm = ($urandom_range(0, 7) == 0) ? 3'($urandom) : XD;
      drive(g, ev, xm);
      n_cmp++;
      if (obs !== m_exp) begin
        n_bad++; $display("FAIL random cyc=%0d sudi=%b got=%h exp=%h", i, g, obs, m_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_link_acq();
    test_full_packet();
    test_early_end();
    test_data_error();
    test_false_carrier();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
